// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and constants for the two-port memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_DONE   = 2'd2;
    localparam state_t ST_ERR    = 2'd3;

    // Requester identifiers
    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    // Width of the ACCESS-cycle counter; at least one bit even when LAT is 1
    function automatic int cnt_width(input int lat);
        return (lat <= 1) ? 1 : $clog2(lat);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin picker. A lone requester always wins; on a
//             tie the requester that did not win last time is picked. The
//             history only advances when the caller accepts the grant.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       grant_en_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    logic rr_last_q;

    // Pick the winner from the current requests and the last winner
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = OWN_CORE;
        if (req_i == 2'b10) begin
            gnt_id_o = OWN_DBG;
        end else if (req_i == 2'b11) begin
            gnt_id_o = ~rr_last_q;
        end
    end

    // Remember the last accepted winner; reset favours the core on the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= OWN_DBG;
        end else if (grant_en_i && gnt_valid_o) begin
            rr_last_q <= gnt_id_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Serialises core and loader/debug accesses onto one shared
//             word-addressed memory with req/ack handshakes, round-robin
//             priority on contention and a misaligned-address error path.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LAT = 1,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    // core port
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic          c_err,
    output logic [DW-1:0] c_rdata,
    // loader / debug port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic          d_err,
    output logic [DW-1:0] d_rdata,
    // memory side
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            CW       = cnt_width(LAT);
    localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

    state_t        state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          own_q,     own_d;
    logic          we_q,      we_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [DW-1:0] wdata_q,   wdata_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic          w_grant_en;
    logic          w_gnt_valid;
    logic          w_gnt_id;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_access;
    logic          w_last;
    logic          w_resp;

    // Arbitration is only meaningful while the FSM is waiting for work
    assign w_grant_en = (state_q == ST_IDLE);

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rst         (rst),
        .req_i       ({d_req, c_req}),
        .grant_en_i  (w_grant_en),
        .gnt_valid_o (w_gnt_valid),
        .gnt_id_o    (w_gnt_id)
    );

    // Steer the winning requester's command toward the latch
    always_comb begin
        w_sel_we    = c_we;
        w_sel_addr  = c_addr;
        w_sel_wdata = c_wdata;
        if (w_gnt_id == OWN_DBG) begin
            w_sel_we    = d_we;
            w_sel_addr  = d_addr;
            w_sel_wdata = d_wdata;
        end
    end

    // Next-state logic: grant and latch, count ACCESS cycles, respond, return
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        own_d     = own_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    own_d   = w_gnt_id;
                    we_d    = w_sel_we;
                    addr_d  = w_sel_addr;
                    wdata_d = w_sel_wdata;
                    cnt_d   = '0;
                    state_d = (|w_sel_addr[1:0]) ? ST_ERR : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    // Only the owner's read buffer is touched, and only on reads
                    if (!we_q) begin
                        if (own_q == OWN_DBG) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            c_rdata_d = mem_rdata;
                        end
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched-request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            own_q     <= OWN_CORE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            own_q     <= own_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign w_access = (state_q == ST_ACCESS);
    assign w_last   = (cnt_q == CNT_LAST);
    assign w_resp   = (state_q == ST_DONE) || (state_q == ST_ERR);

    // Enables are masked by reset so an abandoned write never reaches memory
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = ~rst & w_access & ~we_q;
    assign mem_write = ~rst & w_access & we_q & w_last;

    assign c_ack   = w_resp & (own_q == OWN_CORE);
    assign d_ack   = w_resp & (own_q == OWN_DBG);
    assign c_err   = (state_q == ST_ERR) & (own_q == OWN_CORE);
    assign d_err   = (state_q == ST_ERR) & (own_q == OWN_DBG);
    assign c_rdata = c_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single shared word-addressed memory between two requesters: the multi-cycle core (port c_) and the program/data loader-debug port (port d_).
- Sits between both requesters and the memory file.
- Serializes accesses, holds each requester with a req/ack handshake, and applies round-robin priority on contention.
- The core stalls its state machine while c_req is high and c_ack is low.

Parameters:
- LAT, 1, number of ACCESS cycles per transaction (≥1)
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- c_req  in  1  core request; held until c_ack
- c_we  in  1  core write (1) / read (0)
- c_addr  in  AW  core byte address
- c_wdata  in  DW  core write data
- c_ack  out  1  one-cycle completion pulse to core
- c_err  out  1  misaligned-access flag, valid with c_ack
- c_rdata  out  DW  read data, valid with c_ack
- d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  loader request, same rules as c_
- d_ack, d_err  out  1  loader completion pulse / misaligned flag
- d_rdata  out  DW  loader read data
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable (memory writes on posedge clk)
- mem_rdata  in  DW  memory read data (combinational)

Behaviour:
- Reset: state=IDLE, rr_last=1, all ack/err=0, rdata=0, latched request=0.
- mem_read and mem_write are gated by ~rst combinationally, so a reset cycle never writes.
- States:
  - IDLE: if any req, select owner (see below), latch we/addr/wdata and owner id. Go to ERR if addr[1:0]≠0, else ACCESS with cnt=0.
  - ACCESS: mem_addr=latched addr, mem_wdata=latched wdata. mem_read=~we for all ACCESS cycles; mem_write=we only when cnt==LAT-1 (exactly one write edge). cnt increments each cycle. When cnt==LAT-1: capture mem_rdata into owner's rdata (reads only) and go to DONE.
  - DONE: owner's ack=1 for this one cycle; other port's ack=0. No arbitration. Go to IDLE.
  - ERR: owner's ack=1 and err=1 for one cycle; no memory enables asserted. Go to IDLE.
- Latency: req high in IDLE cycle t → ACCESS cycles t+1..t+LAT → ack in cycle t+LAT+1.
- Back-to-back period is LAT+2 cycles.
- Arbitration (IDLE only):
  - Single requester: that requester is granted.
  - Both requesting: grant the port ≠ rr_last.
  - rr_last updates to the granted id at grant.
  - After reset, the core wins the first tie.
- Requester drops req at or after the ack edge. A req still high during DONE/ERR is ignored; it is re-sampled in IDLE.
- Non-owner rdata holds its previous value; reads never disturb it.
- Inputs changing during ACCESS have no effect, because the request is latched.
- Reset mid-ACCESS: transaction abandoned, no ack ever issued, no write performed if reset lands on the write cycle.
- Address passed unmodified; the memory uses addr[17:2].

Decomposition:
- Package mem_arb_pkg:
  - state typedef {IDLE, ACCESS, DONE, ERR}
  - owner constants OWN_CORE=0, OWN_DBG=1
  - LAT counter width helper
- One natural sub-module: rr_arb2 (2-way round-robin picker with rr_last register and grant-enable input).

Test Plan:
- Core read, LAT=1, mem[4]=32'hDEADBEEF, c_addr=16 at t0 → mem_read in t1, c_ack=1 and c_rdata=DEADBEEF in t2, d_ack=0.
- Loader write d_addr=8, d_wdata=32'h12345678, LAT=3 → mem_write high only in t3, d_ack in t4, mem[2]=12345678; then core read of addr 8 returns 12345678.
- Both req from reset, both reads → core acked first (t2), loader granted in the following IDLE cycle, acked 3 cycles later; repeated contention alternates grants.
- Misaligned c_addr=32'h6 write → c_ack=1, c_err=1 in t1; mem_write never asserted; memory unchanged.
- Reset asserted in the write cycle (LAT=2, cycle t2) → mem_write low, no ack, state IDLE, memory unchanged; the following request completes normally.
- Loader read while core holds req through DONE → core not re-served during DONE; its rdata unchanged by the loader read.
